// File: rtl/fmc_bus_arbiter.sv
// fmc_bus_arbiter
// Shares one downstream memory/register bus between the FMC host slave and a
// local on-chip requester. One transaction is in flight at a time. The host has
// priority, but the local port is guaranteed a slot after MaxHostBurst host
// grants. Accesses that stall downstream are aborted with an error response,
// and the host wait line stretches external FMC cycles while the host is pending.
module fmc_bus_arbiter #(
    parameter int AddrWidth     = 13,
    parameter int DataWidth     = 13,
    parameter int MaxHostBurst  = 4,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // host (FMC slave) port
    input  logic                 h_req_i,
    input  logic                 h_we_i,
    input  logic [AddrWidth-1:0] h_addr_i,
    input  logic [DataWidth-1:0] h_wdata_i,
    output logic                 h_gnt_o,
    output logic                 h_rvalid_o,
    output logic [DataWidth-1:0] h_rdata_o,
    output logic                 h_err_o,
    output logic                 h_wait_o,
    // local requester port
    input  logic                 l_req_i,
    input  logic                 l_we_i,
    input  logic [AddrWidth-1:0] l_addr_i,
    input  logic [DataWidth-1:0] l_wdata_i,
    output logic                 l_gnt_o,
    output logic                 l_rvalid_o,
    output logic [DataWidth-1:0] l_rdata_o,
    output logic                 l_err_o,
    // downstream bus
    output logic                 m_req_o,
    output logic                 m_we_o,
    output logic [AddrWidth-1:0] m_addr_o,
    output logic [DataWidth-1:0] m_wdata_o,
    input  logic                 m_gnt_i,
    input  logic                 m_rvalid_i,
    input  logic [DataWidth-1:0] m_rdata_i
);

    localparam int StarveWidth = $clog2(MaxHostBurst + 1);
    localparam int TimerWidth  = $clog2(TimeoutCycles + 1);
    localparam logic [StarveWidth-1:0] StarveLimit = StarveWidth'(MaxHostBurst);
    localparam logic [TimerWidth-1:0]  TimerLast   = TimerWidth'(TimeoutCycles - 1);
    localparam logic [TimerWidth-1:0]  TimerOne    = TimerWidth'(1);
    localparam logic [StarveWidth-1:0] StarveOne   = StarveWidth'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e                 r_state;
    logic                   r_ownerLocal;
    logic                   r_we;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic                   r_mReq;
    logic [TimerWidth-1:0]  r_timer;
    logic [StarveWidth-1:0] r_starve;
    logic                   r_hRvalid;
    logic                   r_lRvalid;
    logic [DataWidth-1:0]   r_hRdata;
    logic [DataWidth-1:0]   r_lRdata;
    logic                   r_hErr;
    logic                   r_lErr;

    logic                   w_arbOpen;
    logic                   w_localWins;
    logic                   w_hGnt;
    logic                   w_lGnt;
    logic                   w_timerExpired;
    logic                   w_cplValid;
    logic [DataWidth-1:0]   w_cplData;
    logic                   w_cplErr;

    // Arbitrate only in IDLE outside a response cycle; host wins unless the local port has starved long enough
    always_comb begin
        w_arbOpen   = rst_ni && (r_state == ST_IDLE) && !r_hRvalid && !r_lRvalid;
        w_localWins = l_req_i && (r_starve == StarveLimit);
        w_hGnt      = w_arbOpen && h_req_i && !w_localWins;
        w_lGnt      = w_arbOpen && l_req_i && !w_hGnt;
    end

    // Decide whether the in-flight transaction finishes this cycle; a real completion beats the timeout
    always_comb begin
        w_timerExpired = (r_timer >= TimerLast);
        w_cplValid     = 1'b0;
        w_cplData      = '0;
        w_cplErr       = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (m_gnt_i) begin
                    w_cplValid = r_we;
                end else if (w_timerExpired) begin
                    w_cplValid = 1'b1;
                    w_cplData  = '1;
                    w_cplErr   = 1'b1;
                end
            end
            ST_RSP: begin
                if (m_rvalid_i) begin
                    w_cplValid = 1'b1;
                    w_cplData  = m_rdata_i;
                end else if (w_timerExpired) begin
                    w_cplValid = 1'b1;
                    w_cplData  = '1;
                    w_cplErr   = 1'b1;
                end
            end
            default: begin
                w_cplValid = 1'b0;
            end
        endcase
    end

    // Transaction FSM: latch the winner's request, present it downstream, wait for data, count toward timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_ownerLocal <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mReq       <= 1'b0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hGnt || w_lGnt) begin
                        r_state      <= ST_REQ;
                        r_mReq       <= 1'b1;
                        r_ownerLocal <= w_lGnt;
                        r_we         <= w_lGnt ? l_we_i    : h_we_i;
                        r_addr       <= w_lGnt ? l_addr_i  : h_addr_i;
                        r_wdata      <= w_lGnt ? l_wdata_i : h_wdata_i;
                        r_timer      <= '0;
                    end
                end
                ST_REQ: begin
                    if (m_gnt_i) begin
                        r_mReq  <= 1'b0;
                        r_state <= r_we ? ST_IDLE : ST_RSP;
                        r_timer <= r_timer + TimerOne;
                    end else if (w_timerExpired) begin
                        r_mReq  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TimerOne;
                    end
                end
                ST_RSP: begin
                    if (w_cplValid) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TimerOne;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mReq  <= 1'b0;
                end
            endcase
        end
    end

    // Return a one-cycle response to whichever port owns the finished transaction; the other port stays quiet
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hRvalid <= 1'b0;
            r_lRvalid <= 1'b0;
            r_hRdata  <= '0;
            r_lRdata  <= '0;
            r_hErr    <= 1'b0;
            r_lErr    <= 1'b0;
        end else begin
            r_hRvalid <= w_cplValid && !r_ownerLocal;
            r_lRvalid <= w_cplValid && r_ownerLocal;
            r_hRdata  <= (w_cplValid && !r_ownerLocal) ? w_cplData : '0;
            r_lRdata  <= (w_cplValid && r_ownerLocal)  ? w_cplData : '0;
            r_hErr    <= w_cplValid && !r_ownerLocal && w_cplErr;
            r_lErr    <= w_cplValid && r_ownerLocal  && w_cplErr;
        end
    end

    // Count host grants handed out while the local port is waiting; any local grant or idle local port resets it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve <= '0;
        end else if (!l_req_i || w_lGnt) begin
            r_starve <= '0;
        end else if (w_hGnt && (r_starve != StarveLimit)) begin
            r_starve <= r_starve + StarveOne;
        end
    end

    assign h_gnt_o    = w_hGnt;
    assign l_gnt_o    = w_lGnt;
    assign h_rvalid_o = r_hRvalid;
    assign l_rvalid_o = r_lRvalid;
    assign h_rdata_o  = r_hRdata;
    assign l_rdata_o  = r_lRdata;
    assign h_err_o    = r_hErr;
    assign l_err_o    = r_lErr;

    assign m_req_o    = r_mReq;
    assign m_we_o     = r_we;
    assign m_addr_o   = r_addr;
    assign m_wdata_o  = r_wdata;

    assign h_wait_o   = (h_req_i || ((r_state != ST_IDLE) && !r_ownerLocal)) && !r_hRvalid;

endmodule
